// File: rtl/conv_seq_ctrl_pkg.sv
// Shared definitions for the convolution sequencer: instruction bit map,
// FSM state encoding and the idle instruction word.
package conv_seq_ctrl_pkg;
  localparam int INST_W     = 35;
  localparam int AF         = 11;   // width of each memory address field
  localparam int B_RELU     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories disabled (CEN/WEN high), everything else quiet.
  localparam logic [INST_W-1:0] INST_IDLE =
    (INST_W'(1) << B_CEN_P) | (INST_W'(1) << B_WEN_P) |
    (INST_W'(1) << B_CEN_X) | (INST_W'(1) << B_WEN_X);

  typedef enum logic [3:0] {
    S_IDLE, S_KL0, S_GAP_L, S_LOAD, S_GAP_X, S_XL0,
    S_EXEC, S_GAP_D, S_DRAIN, S_ACC, S_RELU
  } state_t;
endpackage

// File: rtl/conv_seq_ctrl_acc_addr.sv
// Maps (output pixel, kernel tap) to the psum memory address read during
// accumulation.
module conv_acc_addr_gen #(
  parameter int IN_W   = 6,
  parameter int K      = 3,
  parameter int ADDR_W = 11
) (
  input  logic [4:0]        onij,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr
);
  localparam int OW      = IN_W - K + 1;
  localparam int LEN_NIJ = IN_W * IN_W;

  logic [4:0] orow, ocol;
  logic [3:0] kr, kc;

  assign orow = onij / 5'(OW);
  assign ocol = onij % 5'(OW);
  assign kr   = k / 4'(K);
  assign kc   = k % 4'(K);
  assign addr = ADDR_W'(k) * ADDR_W'(LEN_NIJ)
              + (ADDR_W'(orow) + ADDR_W'(kr)) * ADDR_W'(IN_W)
              + ADDR_W'(ocol) + ADDR_W'(kc);
endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer issuing one registered core instruction per cycle: per-kernel-tap
// load/execute/drain passes followed by psum accumulation and relu.
module conv_seq_ctrl
  import conv_seq_ctrl_pkg::*;
#(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int IN_W   = 6,
  parameter int K      = 3,
  parameter int GAP    = 10,
  parameter int ADDR_W = 11,
  parameter int W_BASE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_only,
  input  logic              abort,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx,
  output logic [4:0]        onij_idx
);
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int OW       = IN_W - K + 1;
  localparam int LEN_ONIJ = OW * OW;
  localparam int LEN_KIJ  = K * K;
  localparam int CW       = 16;

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [3:0]          kij, kij_d;
  logic [4:0]          onij, onij_d;
  logic [INST_W-1:0]   inst_d;
  logic                done_d, busy_r;
  logic [ADDR_W-1:0]   kl0_addr, drain_addr, acc_addr;

  assign kl0_addr   = ADDR_W'(W_BASE) + ADDR_W'(kij) * ADDR_W'(COL) + ADDR_W'(cnt);
  assign drain_addr = ADDR_W'(kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(cnt);

  conv_acc_addr_gen #(.IN_W(IN_W), .K(K), .ADDR_W(ADDR_W)) u_acc_addr (
    .onij (onij),
    .k    (cnt[3:0]),
    .addr (acc_addr)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    kij_d   = kij;
    onij_d  = onij;
    inst_d  = INST_IDLE;
    done_d  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        // busy_r still high means the final relu is on the bus this cycle
        if (start && !busy_r) begin
          kij_d   = '0;
          onij_d  = '0;
          state_d = acc_only ? S_ACC : S_KL0;
        end
      end
      S_KL0: begin
        inst_d[B_CEN_X]          = 1'b0;
        inst_d[B_AX_LO +: AF]    = AF'(kl0_addr);
        inst_d[B_L0_WR]          = 1'b1;
        if (cnt == CW'(COL - 1)) begin cnt_d = '0; state_d = S_GAP_L; end
      end
      S_GAP_L: if (cnt == CW'(GAP - 1)) begin cnt_d = '0; state_d = S_LOAD; end
      S_LOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
        if (cnt == CW'(COL - 1)) begin cnt_d = '0; state_d = S_GAP_X; end
      end
      S_GAP_X: if (cnt == CW'(GAP - 1)) begin cnt_d = '0; state_d = S_XL0; end
      S_XL0: begin
        inst_d[B_CEN_X]       = 1'b0;
        inst_d[B_AX_LO +: AF] = AF'(cnt);
        inst_d[B_L0_WR]       = 1'b1;
        if (cnt == CW'(LEN_NIJ - 1)) begin cnt_d = '0; state_d = S_EXEC; end
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
        if (cnt == CW'(LEN_NIJ + ROW + COL - 1)) begin cnt_d = '0; state_d = S_GAP_D; end
      end
      S_GAP_D: if (cnt == CW'(GAP - 1)) begin cnt_d = '0; state_d = S_DRAIN; end
      S_DRAIN: begin
        cnt_d = cnt;
        if (ofifo_valid) begin
          inst_d[B_OFIFO_RD]    = 1'b1;
          inst_d[B_CEN_P]       = 1'b0;
          inst_d[B_WEN_P]       = 1'b0;
          inst_d[B_AP_LO +: AF] = AF'(drain_addr);
          cnt_d                 = cnt + CW'(1);
          if (cnt == CW'(LEN_NIJ - 1)) begin
            cnt_d = '0;
            if (kij < 4'(LEN_KIJ - 1)) begin
              kij_d   = kij + 4'd1;
              state_d = S_KL0;
            end else begin
              onij_d  = '0;
              state_d = S_ACC;
            end
          end
        end
      end
      S_ACC: begin
        // reads on cnt 0..LEN_KIJ-1, acc trails each read by one cycle
        if (cnt < CW'(LEN_KIJ)) begin
          inst_d[B_CEN_P]       = 1'b0;
          inst_d[B_AP_LO +: AF] = AF'(acc_addr);
        end
        if (cnt != '0) inst_d[B_ACC] = 1'b1;
        if (cnt == CW'(LEN_KIJ)) begin cnt_d = '0; state_d = S_RELU; end
      end
      S_RELU: begin
        inst_d[B_RELU] = 1'b1;
        cnt_d          = '0;
        if (onij == 5'(LEN_ONIJ - 1)) begin
          done_d  = 1'b1;
          onij_d  = '0;
          kij_d   = '0;
          state_d = S_IDLE;
        end else begin
          onij_d  = onij + 5'd1;
          state_d = S_ACC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      kij_d   = '0;
      onij_d  = '0;
      inst_d  = INST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      kij    <= '0;
      onij   <= '0;
      inst   <= INST_IDLE;
      done   <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      kij    <= kij_d;
      onij   <= onij_d;
      inst   <= inst_d;
      done   <= done_d;
      busy_r <= !abort && (state != S_IDLE);
    end
  end

  assign busy     = (state != S_IDLE) || busy_r;
  assign kij_idx  = kij;
  assign onij_idx = onij;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized bench: a loop-structured program model predicts every
// instruction word, stalling DRAIN on the same random ofifo_valid it drives.
module tb_conv_seq_ctrl;
  localparam int ROW = 8, COL = 8, IN_W = 6, K = 3, GAP = 10, ADDR_W = 11, W_BASE = 1024;
  localparam int LEN_NIJ = IN_W * IN_W, OW = IN_W - K + 1, LEN_ONIJ = OW * OW, LEN_KIJ = K * K;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, acc_only = 1'b0, abort = 1'b0, ofifo_valid = 1'b0;
  logic [34:0] inst;
  logic        busy, done;
  logic [3:0]  kij_idx;
  logic [4:0]  onij_idx;

  int n_tests = 0, n_fail = 0;
  int relu_seen, done_seen, exec_seen, wr_seen, xl_seen;

  conv_seq_ctrl #(.ROW(ROW), .COL(COL), .IN_W(IN_W), .K(K), .GAP(GAP),
                  .ADDR_W(ADDR_W), .W_BASE(W_BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_only(acc_only), .abort(abort),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
    .kij_idx(kij_idx), .onij_idx(onij_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [34:0] idle_i();
    logic [34:0] v;
    v = '0; v[32] = 1'b1; v[31] = 1'b1; v[19] = 1'b1; v[18] = 1'b1;
    return v;
  endfunction

  // One clock: the word on inst after this edge is what the cycle just ended issued.
  task automatic cyc(input string tag, input logic [34:0] e, input logic e_done, input logic e_busy);
    @(posedge clk); #1;
    chk(tag, inst, e);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_busy"}, busy, e_busy);
    if (inst[34]) relu_seen++;
    if (done) done_seen++;
    if (inst[1]) exec_seen++;
    if (!inst[32] && !inst[31]) wr_seen++;
    if (!inst[19] || inst[3:0] != 4'd0) xl_seen++;
  endtask

  task automatic gap_phase();
    for (int i = 0; i < GAP; i++) begin
      start = ($urandom_range(0, 7) == 0);   // must be ignored while busy
      acc_only = 1'($urandom_range(0, 1));
      ofifo_valid = 1'($urandom_range(0, 1));
      cyc("gap", idle_i(), 1'b0, 1'b1);
      start = 1'b0; acc_only = 1'b0;
    end
  endtask

  task automatic do_start(input logic accon);
    start = 1'b1; acc_only = accon;
    cyc("start", idle_i(), 1'b0, 1'b1);
    start = 1'b0; acc_only = 1'b0;
  endtask

  task automatic kl0_phase(input int kij);
    logic [34:0] e;
    for (int i = 0; i < COL; i++) begin
      e = idle_i(); e[19] = 1'b0; e[17:7] = 11'(W_BASE + kij * COL + i); e[2] = 1'b1;
      cyc("kl0", e, 1'b0, 1'b1);
      chk("kij_idx", kij_idx, kij);
    end
  endtask

  task automatic load_phase(input int n);
    logic [34:0] e;
    for (int i = 0; i < n; i++) begin
      e = idle_i(); e[3] = 1'b1; e[0] = 1'b1;
      cyc("load", e, 1'b0, 1'b1);
    end
  endtask

  task automatic model_pass(input int kij);
    logic [34:0] e;
    logic v;
    int n, d;
    exec_seen = 0; wr_seen = 0;
    kl0_phase(kij);
    gap_phase();
    load_phase(COL);
    gap_phase();
    for (int i = 0; i < LEN_NIJ; i++) begin
      e = idle_i(); e[19] = 1'b0; e[17:7] = 11'(i); e[2] = 1'b1;
      cyc("xl0", e, 1'b0, 1'b1);
    end
    for (int i = 0; i < LEN_NIJ + ROW + COL; i++) begin
      e = idle_i(); e[3] = 1'b1; e[1] = 1'b1;
      cyc("exec", e, 1'b0, 1'b1);
    end
    gap_phase();
    n = 0; d = 0;
    while (n < LEN_NIJ && d < 1000) begin
      if (kij == 0 && d < 4) v = (d == 0 || d == 3);
      else v = ($urandom_range(0, 3) != 0);
      ofifo_valid = v;
      e = idle_i();
      if (v) begin
        e[6] = 1'b1; e[32] = 1'b0; e[31] = 1'b0; e[30:20] = 11'(kij * LEN_NIJ + n);
        n++;
      end
      cyc("drain", e, 1'b0, 1'b1);
      d++;
    end
    ofifo_valid = 1'b0;
    chk("exec_len", exec_seen, LEN_NIJ + ROW + COL);
    chk("drain_writes", wr_seen, LEN_NIJ);
  endtask

  task automatic model_acc();
    logic [34:0] e;
    int orow, ocol, a;
    for (int o = 0; o < LEN_ONIJ; o++) begin
      orow = o / OW; ocol = o % OW;
      for (int c = 0; c <= LEN_KIJ; c++) begin
        e = idle_i();
        if (c < LEN_KIJ) begin
          a = c * LEN_NIJ + (orow + c / K) * IN_W + ocol + c % K;
          e[32] = 1'b0; e[30:20] = 11'(a);
        end
        if (c > 0) e[33] = 1'b1;
        cyc("acc", e, 1'b0, 1'b1);
        chk("onij_idx", onij_idx, o);
        if (o == 5 && c == 8) chk("a_pmem_5_8", inst[30:20], 309);
        if (o == 0 && c == 0) chk("a_pmem_0_0", inst[30:20], 0);
      end
      e = idle_i(); e[34] = 1'b1;
      cyc("relu", e, (o == LEN_ONIJ - 1), 1'b1);
    end
    cyc("post_run", idle_i(), 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst", inst, idle_i());
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_kij", kij_idx, 0);
    chk("rst_onij", onij_idx, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) cyc("idle", idle_i(), 1'b0, 1'b0);

    // full run
    relu_seen = 0; done_seen = 0;
    do_start(1'b0);
    for (int k = 0; k < LEN_KIJ; k++) model_pass(k);
    model_acc();
    chk("relu_count", relu_seen, LEN_ONIJ);
    chk("done_count", done_seen, 1);

    // accumulation only
    xl_seen = 0; relu_seen = 0; done_seen = 0;
    do_start(1'b1);
    model_acc();
    chk("acc_only_xl", xl_seen, 0);
    chk("acc_only_relu", relu_seen, LEN_ONIJ);
    chk("acc_only_done", done_seen, 1);

    // asynchronous reset in the middle of EXEC
    do_start(1'b0);
    repeat (92) @(posedge clk);
    #1;
    chk("in_exec", inst[1], 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_inst", inst, idle_i());
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_kij", kij_idx, 0);
    @(negedge clk) reset = 1'b1;
    #1;
    do_start(1'b0);
    kl0_phase(0);
    gap_phase();
    load_phase(3);

    // abort wins over a simultaneous start
    abort = 1'b1; start = 1'b1;
    cyc("abort", idle_i(), 1'b0, 1'b0);
    abort = 1'b0; start = 1'b0;
    repeat (3) cyc("after_abort", idle_i(), 1'b0, 1'b0);
    chk("abort_kij", kij_idx, 0);
    chk("abort_onij", onij_idx, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
